// File: rtl/ysyx_24090018_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ysyx_24090018_wb_pkg
// Brief   : Shared defaults and types for the register-file write arbiter.
// Rev     : 1.0
// ============================================================================
package ysyx_24090018_wb_pkg;

  localparam int NREQ_DEF = 4;
  localparam int AW_DEF   = 5;
  localparam int STAT_W   = 16;

  typedef logic [NREQ_DEF-1:0] grant_t;

endpackage
`default_nettype wire

// File: rtl/ysyx_24090018_rr_pick.sv
`default_nettype none
// ============================================================================
// Module  : ysyx_24090018_rr_pick
// Brief   : Combinational round-robin pick: first valid at or above ptr, wrapping.
// Rev     : 1.0
// ============================================================================
module ysyx_24090018_rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx
);

  always_comb begin
    logic w_found;
    int   w_k;
    grant   = '0;
    idx     = '0;
    w_found = 1'b0;
    w_k     = 0;
    for (int i = 0; i < NREQ; i++) begin
      w_k = (int'(ptr) + i) % NREQ;
      if (!w_found && valid[w_k]) begin
        w_found    = 1'b1;
        grant[w_k] = 1'b1;
        idx        = IW'(w_k);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ysyx_24090018_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : ysyx_24090018_wb_arbiter
// Brief   : Round-robin arbiter for register-file writes, 1-cycle write latency.
//           Grant statistics enabled by YSYX_24090018_WB_ARB_STATS_EN.
// Rev     : 1.0
// ============================================================================
module ysyx_24090018_wb_arbiter
  import ysyx_24090018_wb_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREQ  = NREQ_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
`ifdef YSYX_24090018_WB_ARB_STATS_EN
  input  logic [$clog2(NREQ)-1:0] stat_sel_i,
  output logic [STAT_W-1:0]       stat_cnt_o,
`endif
  input  logic [NREQ-1:0]         req_valid_i,
  input  logic [NREQ*AW-1:0]      req_addr_i,
  input  logic [NREQ*WIDTH-1:0]   req_data_i,
  output logic [NREQ-1:0]         req_ready_o,
  output logic                    wen_o,
  output logic [AW-1:0]           waddr_o,
  output logic [WIDTH-1:0]        wdata_o,
  output logic                    busy_o
);

  localparam int IW = $clog2(NREQ);

  logic [IW-1:0]    r_rr_ptr;
  logic [NREQ-1:0]  w_grant;
  logic [IW-1:0]    w_idx;
  logic             w_xfer;
  logic [AW-1:0]    w_addr;
  logic [WIDTH-1:0] w_data;

  ysyx_24090018_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .valid (req_valid_i),
    .ptr   (r_rr_ptr),
    .grant (w_grant),
    .idx   (w_idx)
  );

  assign req_ready_o = rst ? '0 : w_grant;
  assign w_xfer      = |req_ready_o;
  assign busy_o      = |req_valid_i;
  assign w_addr      = req_addr_i[w_idx*AW +: AW];
  assign w_data      = req_data_i[w_idx*WIDTH +: WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
      wen_o    <= 1'b0;
      waddr_o  <= '0;
      wdata_o  <= '0;
    end else begin
      // x0 is hardwired: the transfer is acknowledged but never written
      wen_o <= w_xfer && (w_addr != '0);
      if (w_xfer) begin
        r_rr_ptr <= (w_idx == IW'(NREQ-1)) ? '0 : w_idx + 1'b1;
        waddr_o  <= w_addr;
        wdata_o  <= w_data;
      end
    end
  end

`ifdef YSYX_24090018_WB_ARB_STATS_EN
  logic [NREQ-1:0][STAT_W-1:0] r_stat_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_cnt <= '0;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        if (req_ready_o[k] && (r_stat_cnt[k] != '1))
          r_stat_cnt[k] <= r_stat_cnt[k] + 1'b1;
      end
    end
  end

  assign stat_cnt_o = r_stat_cnt[stat_sel_i];
`endif

endmodule
`default_nettype wire

// File: tb/tb_ysyx_24090018_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_ysyx_24090018_wb_arbiter
// Brief   : Directed bench with a per-cycle reference model of the arbiter.
// Rev     : 1.0
// ============================================================================
module tb_ysyx_24090018_wb_arbiter;
  import ysyx_24090018_wb_pkg::*;

  localparam int N = 4;

  logic          clk;
  logic          rst;
  logic [N-1:0]  valid;
  logic [4:0]    a [N];
  logic [31:0]   d [N];
  logic [N*5-1:0]  req_addr;
  logic [N*32-1:0] req_data;
  logic [N-1:0]  ready;
  logic          wen;
  logic [4:0]    waddr;
  logic [31:0]   wdata;
  logic          busy;
`ifdef YSYX_24090018_WB_ARB_STATS_EN
  logic [1:0]    stat_sel;
  logic [15:0]   stat_cnt;
`endif

  assign req_addr = {a[3], a[2], a[1], a[0]};
  assign req_data = {d[3], d[2], d[1], d[0]};

  ysyx_24090018_wb_arbiter #(.WIDTH(32), .NREQ(N), .AW(5)) dut (
    .clk         (clk),
    .rst         (rst),
`ifdef YSYX_24090018_WB_ARB_STATS_EN
    .stat_sel_i  (stat_sel),
    .stat_cnt_o  (stat_cnt),
`endif
    .req_valid_i (valid),
    .req_addr_i  (req_addr),
    .req_data_i  (req_data),
    .req_ready_o (ready),
    .wen_o       (wen),
    .waddr_o     (waddr),
    .wdata_o     (wdata),
    .busy_o      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit started  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pointer, pending write and last payload
  int          m_ptr;
  logic        m_wen;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  bit          m_known;

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int i = 0; i < N; i++)
      if (v[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  always @(posedge clk) begin
    int g;
    g = pick(valid, m_ptr);
    if (rst) begin
      m_ptr <= 0; m_wen <= 1'b0; m_waddr <= '0; m_wdata <= '0; m_known <= 1'b1;
    end else if (g >= 0) begin
      m_ptr <= (g + 1) % N;
      m_wen <= (a[g] != 5'd0);
      m_waddr <= a[g];
      m_wdata <= d[g];
      m_known <= (a[g] != 5'd0);
    end else begin
      m_wen <= 1'b0;
    end
  end

  always @(negedge clk) begin
    logic [N-1:0] er;
    int g;
    if (started) begin
      er = '0;
      g = pick(valid, m_ptr);
      if (!rst && g >= 0) er[g] = 1'b1;
      check("model_ready", 64'(ready), 64'(er));
      check("model_busy", 64'(busy), 64'(|valid));
      check("model_wen", 64'(wen), 64'(m_wen));
      if (m_known) begin
        check("model_waddr", 64'(waddr), 64'(m_waddr));
        check("model_wdata", 64'(wdata), 64'(m_wdata));
      end
    end
  end

  task automatic cyc(input logic r, input logic [N-1:0] v);
    @(posedge clk);
    #1;
    rst   = r;
    valid = v;
    #2;
  endtask

  initial begin
    grant_t exp_rdy [5];
    logic [4:0] exp_lag [4];
    exp_rdy = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_lag = '{5'd10, 5'd11, 5'd12, 5'd13};
    rst = 1'b1;
    valid = '0;
    for (int k = 0; k < N; k++) begin a[k] = '0; d[k] = '0; end
`ifdef YSYX_24090018_WB_ARB_STATS_EN
    stat_sel = 2'd3;
`endif

    // Reset then idle
    cyc(1'b1, 4'b0000);
    started = 1'b1;
    check("rst_ready", 64'(ready), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    cyc(1'b1, 4'b0000);
    check("rst_wen", 64'(wen), 64'h0);
    check("rst_waddr", 64'(waddr), 64'h0);
    check("rst_wdata", 64'(wdata), 64'h0);
    cyc(1'b0, 4'b0000);

    // Single write from requester 1
    a[1] = 5'd5; d[1] = 32'hDEADBEEF;
    cyc(1'b0, 4'b0010);
    check("single_ready", 64'(ready), 64'h2);
    check("single_busy", 64'(busy), 64'h1);
    cyc(1'b0, 4'b0000);
    check("single_wen", 64'(wen), 64'h1);
    check("single_waddr", 64'(waddr), 64'h5);
    check("single_wdata", 64'(wdata), 64'hDEADBEEF);
    cyc(1'b0, 4'b0000);
    check("single_wen_off", 64'(wen), 64'h0);
    check("single_hold", 64'(waddr), 64'h5);

    // Full contention after a fresh reset
    cyc(1'b1, 4'b0000);
    for (int k = 0; k < N; k++) begin
      a[k] = 5'(10 + k);
      d[k] = 32'hA000_0000 + 32'(k);
    end
    for (int j = 0; j < 5; j++) begin
      cyc(1'b0, 4'b1111);
      check("rr_ready", 64'(ready), 64'(exp_rdy[j]));
      if (j > 0) begin
        check("rr_waddr", 64'(waddr), 64'(exp_lag[j-1]));
        check("rr_wen", 64'(wen), 64'h1);
      end
    end
    cyc(1'b0, 4'b0000);
    check("rr_last_waddr", 64'(waddr), 64'd10);
    check("rr_last_wdata", 64'(wdata), 64'hA000_0000);

    // x0 suppression from requester 2 (pointer is 1 here)
    a[2] = 5'd0; d[2] = 32'h1234;
    cyc(1'b0, 4'b0100);
    check("x0_ready", 64'(ready), 64'h4);
    cyc(1'b0, 4'b1111);
    check("x0_wen", 64'(wen), 64'h0);
    check("x0_ptr3", 64'(ready), 64'h8);
    cyc(1'b0, 4'b0000);
    check("after_x0_waddr", 64'(waddr), 64'd13);

    // Reset right after a transfer cancels its write
    cyc(1'b0, 4'b0010);
    check("mid_ready", 64'(ready), 64'h2);
    cyc(1'b1, 4'b1111);
    check("mid_rst_ready", 64'(ready), 64'h0);
    cyc(1'b0, 4'b1111);
    check("mid_wen", 64'(wen), 64'h0);
    check("mid_waddr", 64'(waddr), 64'h0);
    check("mid_ready0", 64'(ready), 64'h1);
    cyc(1'b0, 4'b0000);

`ifdef YSYX_24090018_WB_ARB_STATS_EN
    cyc(1'b1, 4'b0000);
    for (int j = 0; j < 3; j++) begin
      cyc(1'b0, 4'b1000);
      check("st_ready", 64'(ready), 64'h8);
    end
    cyc(1'b0, 4'b0000);
    check("st_cnt3", 64'(stat_cnt), 64'd3);
    force dut.r_stat_cnt = {16'hFFFF, 16'h0, 16'h0, 16'h0};
    cyc(1'b0, 4'b0000);
    release dut.r_stat_cnt;
    cyc(1'b0, 4'b1000);
    cyc(1'b0, 4'b0000);
    check("st_sat", 64'(stat_cnt), 64'hFFFF);
`endif

    cyc(1'b0, 4'b0000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ysyx_24090018_wb_arbiter.md
YSYX_24090018_WB_ARBITER -- requirements
Module: ysyx_24090018_wb_arbiter

Interface
REQ-001 The block SHALL have the following parameters:
- WIDTH, default 32: write-data width.
- NREQ, default 4: number of requesters.
- AW, default 5: register address width.
REQ-002 The block SHALL have the following ports, one clock and one reset; reset is synchronous and active-high:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous active-high reset.
- req_valid_i  in  NREQ  per-requester write request.
- req_addr_i  in  NREQ*AW  flat addresses; requester k occupies bits [k*AW +: AW].
- req_data_i  in  NREQ*WIDTH  flat data; requester k occupies bits [k*WIDTH +: WIDTH].
- req_ready_o  out  NREQ  one-hot grant, combinational.
- wen_o  out  1  register-file write enable, registered.
- waddr_o  out  AW  write address, registered.
- wdata_o  out  WIDTH  write data, registered.
- busy_o  out  1  any req_valid_i high this cycle.

Function
REQ-003 A transfer for requester k SHALL occur in a cycle where req_valid_i[k] and req_ready_o[k] are both 1.
REQ-004 req_ready_o SHALL be all zeros or exactly one-hot; at most one transfer SHALL occur per cycle.
REQ-005 req_ready_o[k] SHALL be 1 only if req_valid_i[k] is 1.
- ready is a pure function of req_valid_i and the pointer rr_ptr.
- ready SHALL NOT depend on addr or data.
REQ-006 Round-robin arbitration SHALL grant the first valid requester found scanning upward from rr_ptr, modulo NREQ.
REQ-007 After a transfer by requester g, rr_ptr SHALL become (g+1) mod NREQ on the next edge. Without a transfer, rr_ptr SHALL hold.
REQ-008 Write latency SHALL be 1 cycle: a transfer at edge n drives wen_o, waddr_o and wdata_o during cycle n+1 with the granted payload.
REQ-009 A transfer with address 0 SHALL be acknowledged, but wen_o SHALL stay 0 in cycle n+1 (x0 is hardwired).
REQ-010 In a cycle with no transfer, the following edge SHALL drive wen_o to 0. waddr_o and wdata_o SHALL hold their last values.
REQ-011 A requester SHALL hold valid, addr and data stable until its transfer. The arbiter is not required to tolerate a valid withdrawn before ready.
REQ-012 With all NREQ requesters continuously valid, grants SHALL rotate 0,1,2,3,0,... and no requester SHALL wait more than NREQ-1 cycles.
REQ-013 busy_o SHALL equal the OR-reduction of req_valid_i.

Reset
REQ-014 While rst is 1 at a rising edge:
- rr_ptr SHALL be set to 0.
- wen_o, waddr_o and wdata_o SHALL be set to 0.
- all statistics counters SHALL be set to 0 (when present).
REQ-015 While rst is 1, req_ready_o SHALL be forced to all zeros. No transfer occurs, even with valid requests.
REQ-016 A reset asserted in the cycle after a transfer SHALL cancel the pending write: wen_o is 0 in the cycle after reset.

Configuration
REQ-017 The macro YSYX_24090018_WB_ARB_STATS_EN SHALL control the grant-statistics feature.
REQ-018 When YSYX_24090018_WB_ARB_STATS_EN is defined:
- the block SHALL add input stat_sel_i (width clog2(NREQ)) and output stat_cnt_o (width 16).
- the block SHALL keep one 16-bit grant counter per requester.
- each counter SHALL increment on every transfer by its requester, including address-0 transfers.
- each counter SHALL saturate at 0xFFFF.
- stat_cnt_o SHALL show the counter selected by stat_sel_i, combinationally.
REQ-019 When YSYX_24090018_WB_ARB_STATS_EN is undefined, these ports and counters SHALL NOT exist. All other behaviour SHALL be identical.

Structure
REQ-020 A shared package ysyx_24090018_wb_pkg SHALL hold:
- the default constants NREQ_DEF=4, AW_DEF=5 and STAT_W=16.
- a typedef for the one-hot grant vector.
REQ-021 Round-robin selection SHALL live in a combinational sub-module, ysyx_24090018_rr_pick.
- inputs: valid vector and pointer.
- outputs: one-hot grant and its encoded index.
REQ-022 All state SHALL reside in ysyx_24090018_wb_arbiter:
- rr_ptr.
- the output register.
- the counters.

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
- Reset then idle: rst=1 for 2 cycles, all valid=0 -> ready=0000, wen_o=0, waddr_o=0, wdata_o=0, busy_o=0.
- Single write: valid=0010, addr1=5, data1=0xDEADBEEF -> ready=0010 the same cycle; the next cycle wen_o=1, waddr_o=5, wdata_o=0xDEADBEEF; the cycle after, wen_o=0.
- Full contention: valid=1111 held, payload fixed per requester -> grants 0,1,2,3,0 on consecutive cycles; waddr_o and wdata_o follow with 1-cycle lag.
- x0 suppression: requester 2 writes addr 0, data 0x1234 -> ready=0100 and the transfer completes; wen_o stays 0 the next cycle; rr_ptr advances to 3.
- Reset mid-operation: transfer at edge n, rst=1 during cycle n+1 -> wen_o=0 after that edge, rr_ptr=0, and the next grant with valid=1111 goes to requester 0.
- Stats (macro defined): requester 3 wins 3 transfers, stat_sel_i=3 -> stat_cnt_o=3. With the counter preloaded to 0xFFFF, one more win -> stat_cnt_o stays 0xFFFF.
